// File: rtl/reg_writeback_ctrl.sv
// Writeback request FIFO feeding a one-write-per-clock register file, with a
// per-register pending scoreboard for read-after-write hazard stalls.
module reg_writeback_ctrl #(
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 4,
    parameter int IDX_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wb_valid,
    output logic                               wb_ready,
    input  logic [IDX_W-1:0]                   wb_idx,
    input  logic [DATA_W-1:0]                  wb_data,
    output logic [NUM_REGS-1:0][DATA_W-1:0]    regs_in,
    output logic [NUM_REGS-1:0]                write_en,
    output logic [NUM_REGS-1:0]                pending,
    output logic                               idx_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SB_W  = $clog2(FIFO_DEPTH + 2) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W:0]   NUM_REGS_C = (IDX_W + 1)'(NUM_REGS);

    logic [IDX_W-1:0]  fifo_idx_q  [FIFO_DEPTH];
    logic [IDX_W-1:0]  fifo_idx_d  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_in_q, regs_in_d;
    logic [NUM_REGS-1:0]             write_en_q, write_en_d;
    logic                            idx_err_q, idx_err_d;
    logic [SB_W-1:0]                 sb_cnt_q [NUM_REGS];
    logic [SB_W-1:0]                 sb_cnt_d [NUM_REGS];

    logic              accept;
    logic              idx_ok;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  head_idx;
    logic [DATA_W-1:0] head_data;

    // Ready ignores a same-cycle pop so a full FIFO never takes a bypass path.
    assign wb_ready  = !rst && (count_q < DEPTH_C);
    assign accept    = wb_valid && wb_ready;
    assign idx_ok    = {1'b0, wb_idx} < NUM_REGS_C;
    assign push      = accept && idx_ok;
    assign pop       = (count_q != '0);
    assign head_idx  = fifo_idx_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    assign regs_in  = regs_in_q;
    assign write_en = write_en_q;
    assign idx_err  = idx_err_q;

    always_comb begin
        fifo_idx_d  = fifo_idx_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        write_en_d  = '0;
        regs_in_d   = '0;
        idx_err_d   = accept && !idx_ok;

        if (push) begin
            fifo_idx_d[wr_ptr_q]  = wb_idx;
            fifo_data_d[wr_ptr_q] = wb_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            for (int r = 0; r < NUM_REGS; r++) begin
                if (head_idx == IDX_W'(r)) begin
                    write_en_d[r] = 1'b1;
                    regs_in_d[r]  = head_data;
                end
            end
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A register stays pending until the edge that ends its write_en cycle.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            sb_cnt_d[r] = sb_cnt_q[r];
            if ((push && (wb_idx == IDX_W'(r))) && !write_en_q[r]) begin
                sb_cnt_d[r] = sb_cnt_q[r] + SB_W'(1);
            end else if (!(push && (wb_idx == IDX_W'(r))) && write_en_q[r]) begin
                sb_cnt_d[r] = sb_cnt_q[r] - SB_W'(1);
            end
            pending[r] = (sb_cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            write_en_q <= '0;
            regs_in_q  <= '0;
            idx_err_q  <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                sb_cnt_q[r] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            write_en_q <= write_en_d;
            regs_in_q  <= regs_in_d;
            idx_err_q  <= idx_err_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                sb_cnt_q[r] <= sb_cnt_d[r];
            end
        end
    end

    // Entry storage is only meaningful between pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        fifo_idx_q  <= fifo_idx_d;
        fifo_data_q <= fifo_data_d;
    end

endmodule
